// File: rtl/md5_hit_collector.sv
// Hit collector: re-associates MD5 pipeline hits with issued candidates,
// buffers matches in a FWFT FIFO and tracks end-of-search.
module md5_hit_collector #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 64,
  parameter int DEPTH   = 4
) (
  input  logic             CLK,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             cand_valid,
  input  logic [WIDTH-1:0] cand,
  input  logic             hit,
  input  logic             done_in,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             hold,
  output logic [15:0]      hit_count,
  output logic             overflow,
  output logic             spurious,
  output logic             all_done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);
  localparam logic [AW:0] HOLD_AT = (AW+1)'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    FINISHED
  } state_t;

  state_t state, state_nxt;
  logic [CW-1:0] dcnt, dcnt_nxt;

  logic [LATENCY-1:0] dl_v;
  logic [WIDTH-1:0]   dl_c [LATENCY];
  logic               rec;
  logic               tap_v;
  logic [WIDTH-1:0]   tap_c;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      count, count_nxt;
  logic             empty, full;
  logic             push_req, push, pop, drop;

  // Candidates stop entering the delay line once the search is over
  assign rec   = cand_valid & ((state == IDLE) | (state == RUN));
  assign tap_v = dl_v[LATENCY-1];
  assign tap_c = dl_c[LATENCY-1];

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      dl_v <= '0;
    end else if (clear) begin
      dl_v <= '0;
    end else begin
      dl_v[0] <= rec;
      for (int i = 1; i < LATENCY; i++)
        dl_v[i] <= dl_v[i-1];
    end
  end

  always_ff @(posedge CLK) begin
    dl_c[0] <= cand;
    for (int i = 1; i < LATENCY; i++)
      dl_c[i] <= dl_c[i-1];
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;

  assign pop       = !empty & out_ready;
  assign push_req  = hit & tap_v;
  assign push      = push_req & (!full | pop);
  assign drop      = push_req & full & !pop;
  assign count_nxt = count + (AW+1)'(push) - (AW+1)'(pop);

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (push && !clear)
      mem[wr_ptr[AW-1:0]] <= tap_c;
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
      spurious  <= 1'b0;
      hold      <= 1'b0;
      all_done  <= 1'b0;
    end else if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      hit_count <= '0;
      overflow  <= 1'b0;
      spurious  <= 1'b0;
      hold      <= 1'b0;
      all_done  <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push && hit_count != 16'hFFFF)
        hit_count <= hit_count + 16'd1;
      if (drop)
        overflow <= 1'b1;
      if (hit && !tap_v)
        spurious <= 1'b1;
      hold     <= (count_nxt >= HOLD_AT);
      all_done <= (state_nxt == FINISHED) &&
                  (count_nxt == '0);
    end
  end

  always_ff @(posedge CLK or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      dcnt  <= '0;
    end else begin
      state <= state_nxt;
      dcnt  <= dcnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    dcnt_nxt  = dcnt;
    if (clear) begin
      state_nxt = IDLE;
      dcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          if (done_in) begin
            state_nxt = DRAIN;
            dcnt_nxt  = CW'(LATENCY);
          end else if (cand_valid) begin
            state_nxt = RUN;
          end
        end
        RUN: begin
          if (done_in) begin
            state_nxt = DRAIN;
            dcnt_nxt  = CW'(LATENCY);
          end
        end
        DRAIN: begin
          dcnt_nxt = dcnt - CW'(1);
          if (dcnt == CW'(1))
            state_nxt = FINISHED;
        end
        FINISHED: ;
        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md5_hit_collector.sv
// Bench for md5_hit_collector: directed table, corner sequences and
// randomized traffic against a cycle-indexed reference model.
module tb_md5_hit_collector;

  localparam int LAT = 4;
  localparam int DP  = 4;
  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DRN  = 2;
  localparam int M_FIN  = 3;

  logic        clk = 0;
  logic        reset_n;
  logic        clr, cv, hit, dn, rdy;
  logic [31:0] cd;
  logic        out_valid;
  logic [31:0] out_data;
  logic        hold;
  logic [15:0] hit_count;
  logic        overflow, spurious, all_done;

  md5_hit_collector #(
    .WIDTH(32), .LATENCY(LAT), .DEPTH(DP)
  ) dut (
    .CLK(clk), .reset_n(reset_n), .clear(clr),
    .cand_valid(cv), .cand(cd), .hit(hit),
    .done_in(dn), .out_valid(out_valid),
    .out_data(out_data), .out_ready(rdy),
    .hold(hold), .hit_count(hit_count),
    .overflow(overflow), .spurious(spurious),
    .all_done(all_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: candidates recorded by absolute cycle number
  bit          rec_v [int];
  logic [31:0] rec_c [int];
  logic [31:0] mq [$];
  int          ncyc = 0;
  int          ms = M_IDLE;
  int          dend = 0;
  int          mhc = 0;
  bit          movf = 0;
  bit          mspur = 0;

  typedef struct {
    logic cv; logic [31:0] c; logic h; logic dn;
    logic rdy; logic clr;
    logic ov; logic [31:0] d; logic [15:0] hc;
    logic ovf; logic sp; logic hd;
  } vec_t;
  vec_t tbl [$];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    rec_v.delete();
    rec_c.delete();
    mq.delete();
    ms    = M_IDLE;
    mhc   = 0;
    movf  = 0;
    mspur = 0;
  endtask

  task automatic model_edge();
    bit tv;
    logic [31:0] tc;
    logic [31:0] tmp;
    bit pop;
    int k;
    k = ncyc - LAT;
    if (clr) begin
      model_reset();
    end else begin
      tv = rec_v.exists(k) ? rec_v[k] : 1'b0;
      tc = rec_c.exists(k) ? rec_c[k] : '0;
      if (rec_v.exists(k)) begin
        rec_v.delete(k);
        rec_c.delete(k);
      end
      rec_v[ncyc] = cv && (ms == M_IDLE || ms == M_RUN);
      rec_c[ncyc] = cd;
      pop = (mq.size() != 0) && rdy;
      if (pop) tmp = mq.pop_front();
      if (hit) begin
        if (!tv) mspur = 1;
        else if (mq.size() < DP) begin
          mq.push_back(tc);
          if (mhc < 65535) mhc++;
        end else movf = 1;
      end
      case (ms)
        M_IDLE: if (dn) begin
          ms = M_DRN; dend = ncyc + LAT;
        end else if (cv) ms = M_RUN;
        M_RUN: if (dn) begin
          ms = M_DRN; dend = ncyc + LAT;
        end
        M_DRN: if (ncyc == dend) ms = M_FIN;
        default: ;
      endcase
    end
    ncyc++;
  endtask

  task automatic model_cmp();
    int n;
    n = mq.size();
    chk("out_valid", out_valid, n != 0);
    chk("out_data", out_data, (n != 0) ? mq[0] : 32'h0);
    chk("hold", hold, n >= DP - 1);
    chk("hit_count", hit_count, mhc);
    chk("overflow", overflow, movf);
    chk("spurious", spurious, mspur);
    chk("all_done", all_done, (ms == M_FIN) && (n == 0));
  endtask

  task automatic step(input logic v, input logic [31:0] c,
                      input logic h, input logic d,
                      input logic r, input logic cl);
    cv = v; cd = c; hit = h; dn = d; rdy = r; clr = cl;
    @(posedge clk);
    model_edge();
    #1;
    model_cmp();
  endtask

  task automatic add(input logic v, input logic [31:0] c,
                     input logic h, input logic d,
                     input logic r, input logic cl,
                     input logic ov, input logic [31:0] od,
                     input logic [15:0] hc, input logic ovf,
                     input logic sp, input logic hd);
    vec_t e;
    e.cv = v; e.c = c; e.h = h; e.dn = d; e.rdy = r; e.clr = cl;
    e.ov = ov; e.d = od; e.hc = hc;
    e.ovf = ovf; e.sp = sp; e.hd = hd;
    tbl.push_back(e);
  endtask

  task automatic fill_two();
    step(0, 0, 0, 0, 0, 1);
    step(1, 32'hA, 0, 0, 0, 0);
    step(1, 32'hB, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("fill_valid", out_valid, 1);
    chk("fill_head", out_data, 32'hA);
  endtask

  initial begin
    // alignment: cand 5 hit 4 cycles later
    for (int k = 0; k < 9; k++)
      add(1, k, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 9, 1, 0, 0, 0, 1, 5, 1, 0, 0, 0);
    add(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
    // backpressure / overflow
    for (int k = 2; k < 6; k++)
      add(1, k, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    add(1, 6, 1, 0, 0, 0, 1, 2, 2, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 2, 3, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 2, 4, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1, 2, 5, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1, 2, 5, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 1, 3, 5, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0, 1, 4, 5, 1, 0, 0);
    add(0, 0, 0, 0, 1, 0, 1, 5, 5, 1, 0, 0);
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    // push+pop at full, then spurious
    for (int k = 16; k < 20; k++)
      add(1, k, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 20, 1, 0, 0, 0, 1, 16, 1, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 16, 2, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 1, 16, 3, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1, 16, 4, 0, 0, 1);
    add(0, 0, 1, 0, 1, 0, 1, 17, 5, 0, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1, 17, 5, 0, 1, 1);
    add(0, 0, 0, 0, 1, 0, 1, 18, 5, 0, 1, 1);

    reset_n = 0;
    cv = 0; cd = 0; hit = 0; dn = 0; rdy = 0; clr = 0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1;
    model_cmp();

    foreach (tbl[i]) begin
      step(tbl[i].cv, tbl[i].c, tbl[i].h,
           tbl[i].dn, tbl[i].rdy, tbl[i].clr);
      chk($sformatf("t%0d_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("t%0d_data", i), out_data, tbl[i].d);
      chk($sformatf("t%0d_count", i), hit_count, tbl[i].hc);
      chk($sformatf("t%0d_ovf", i), overflow, tbl[i].ovf);
      chk($sformatf("t%0d_spur", i), spurious, tbl[i].sp);
      chk($sformatf("t%0d_hold", i), hold, tbl[i].hd);
    end

    // drain and end-of-search
    step(0, 0, 0, 0, 1, 1);
    step(1, 32'h1, 0, 0, 0, 0);
    step(1, 32'hFFFFFFFF, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 1, 0, 0);
      chk("drain_done", all_done, 0);
    end
    step(0, 0, 1, 1, 0, 0);
    chk("last_data", out_data, 32'hFFFFFFFF);
    chk("fin_nonempty", all_done, 0);
    step(0, 0, 0, 1, 0, 0);
    chk("fin_wait", all_done, 0);
    step(0, 0, 0, 1, 1, 0);
    chk("fin_done", all_done, 1);
    chk("fin_empty", out_valid, 0);
    step(0, 0, 1, 1, 0, 0);
    chk("fin_spur", spurious, 1);
    chk("fin_count", hit_count, 1);

    // asynchronous reset mid-run
    fill_two();
    #2;
    reset_n = 0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_data", out_data, 0);
    chk("ar_hold", hold, 0);
    chk("ar_count", hit_count, 0);
    chk("ar_ovf", overflow, 0);
    chk("ar_spur", spurious, 0);
    chk("ar_done", all_done, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1;

    // synchronous clear mid-run, FSM back to IDLE
    fill_two();
    step(0, 0, 0, 0, 0, 1);
    chk("clr_valid", out_valid, 0);
    chk("clr_count", hit_count, 0);
    step(0, 0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 0, 0, 0, 0);
      chk("clr_drain", all_done, 0);
    end
    step(0, 0, 0, 0, 0, 0);
    chk("clr_fin", all_done, 1);

    // randomized traffic
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 1500; k++) begin
      step($urandom_range(0, 9) < 7, $urandom,
           $urandom_range(0, 1),
           $urandom_range(0, 39) == 0,
           $urandom_range(0, 2) != 0,
           $urandom_range(0, 59) == 0);
    end

    // hit_count saturation
    step(0, 0, 0, 0, 0, 1);
    for (int k = 0; k < 65545; k++)
      step(1, k, 1, 0, 1, 0);
    chk("sat_count", hit_count, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
